// File: rtl/vp_cfg_pkg.sv
// Shared constants and types for the video-process configuration controller.
package vp_cfg_pkg;

    localparam int unsigned CFG_W     = 12;
    localparam int unsigned SCALE_W   = 18;
    localparam int unsigned DIV_STEPS = 26;
    localparam int unsigned DVD_W     = 26;

    localparam logic [2:0] ADDR_START  = 3'd0;
    localparam logic [2:0] ADDR_END    = 3'd1;
    localparam logic [2:0] ADDR_OUTRES = 3'd2;
    localparam logic [2:0] ADDR_CTRL   = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd1;
    localparam logic [2:0] ST_DIVX   = 3'd2;
    localparam logic [2:0] ST_DIVY   = 3'd3;
    localparam logic [2:0] ST_PEND   = 3'd4;
    localparam logic [2:0] ST_COMMIT = 3'd5;

    typedef struct packed {
        logic [CFG_W-1:0] sx;
        logic [CFG_W-1:0] sy;
        logic [CFG_W-1:0] ex;
        logic [CFG_W-1:0] ey;
        logic [CFG_W-1:0] oxr;
        logic [CFG_W-1:0] oyr;
        logic [1:0]       mode;
        logic             sen;
    } cfg_t;

    localparam cfg_t CFG_RST = '{
        sx: 12'd0, sy: 12'd0, ex: 12'd1280, ey: 12'd720,
        oxr: 12'd1279, oyr: 12'd719, mode: 2'b01, sen: 1'b1
    };

    localparam logic [SCALE_W-1:0] SCALE_RST = 18'h04000;

    function automatic logic [31:0] pack_xy(input logic [CFG_W-1:0] x, input logic [CFG_W-1:0] y);
        return {4'd0, y, 4'd0, x};
    endfunction

endpackage

// File: rtl/vp_div_serial.sv
// Restoring serial divider: one quotient bit per cycle, DIV_STEPS cycles per divide.
module vp_div_serial
    import vp_cfg_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DVD_W-1:0]       dividend,
    input  logic [CFG_W-1:0]       divisor_m1,
    output logic                   done,
    output logic [SCALE_W-1:0]     quotient
);

    logic [DVD_W-1:0] aq;
    logic [CFG_W:0]   dvs;
    logic [CFG_W:0]   rem;
    logic [CFG_W+1:0] rem_sh;
    logic [CFG_W+1:0] diff;
    logic [CFG_W:0]   rem_nx;
    logic             qbit;
    logic [4:0]       cnt;
    logic             run;

    // done/quotient reflect the step being taken this cycle, so the caller
    // can capture the result and restart on the same edge.
    always_comb begin
        rem_sh   = {rem, aq[DVD_W-1]};
        diff     = rem_sh - {1'b0, dvs};
        qbit     = (rem_sh >= {1'b0, dvs});
        rem_nx   = qbit ? (CFG_W+1)'(diff) : (CFG_W+1)'(rem_sh);
        done     = run && (cnt == 5'(DIV_STEPS - 1));
        quotient = {aq[SCALE_W-2:0], qbit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aq  <= '0;
            dvs <= '0;
            rem <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            aq  <= dividend;
            dvs <= {1'b0, divisor_m1} + (CFG_W+1)'(1);
            rem <= '0;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            aq  <= {aq[DVD_W-2:0], qbit};
            rem <= rem_nx;
            cnt <= cnt + 5'd1;
            if (done) run <= 1'b0;
        end
    end

endmodule

// File: rtl/vp_cfg_ctrl.sv
// Frame-synchronous configuration controller: staging registers, geometry check,
// scale computation and vsync-aligned atomic commit of crop/filter/scaler settings.
module vp_cfg_ctrl
    import vp_cfg_pkg::*;
#(
    parameter int unsigned H_DISP     = 1280,
    parameter int unsigned V_DISP     = 720,
    parameter int unsigned RES_W      = 12,
    parameter int unsigned SCALE_FRAC = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [2:0]         addr,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    input  logic               vs_i,
    output logic [RES_W-1:0]   start_x,
    output logic [RES_W-1:0]   start_y,
    output logic [RES_W-1:0]   end_x,
    output logic [RES_W-1:0]   end_y,
    output logic [RES_W-1:0]   out_x_res,
    output logic [RES_W-1:0]   out_y_res,
    output logic [SCALE_W-1:0] x_scale,
    output logic [SCALE_W-1:0] y_scale,
    output logic [1:0]         filter_mode,
    output logic               scaler_en,
    output logic               busy,
    output logic               pending,
    output logic               cfg_err,
    output logic               commit
);

    localparam logic [CFG_W:0] H_MAX = (CFG_W+1)'(H_DISP);
    localparam logic [CFG_W:0] V_MAX = (CFG_W+1)'(V_DISP);

    logic [2:0]         state;
    cfg_t               stg, stg_nx, snap, act;
    logic [SCALE_W-1:0] res_xs, res_ys, act_xs, act_ys;
    logic               vs_q, vs_rise, apply, accept, geom_bad;
    logic [CFG_W-1:0]   in_w, in_h;
    logic [CFG_W+4:0]   lim_w, lim_h;
    logic               div_start, div_done;
    logic [DVD_W-1:0]   div_dvd;
    logic [CFG_W-1:0]   div_dsr;
    logic [SCALE_W-1:0] div_q;
    logic               unused_wr_bits;

    assign unused_wr_bits = ^{wr_data[30:28], wr_data[15:12]};

    always_comb begin
        stg_nx = stg;
        if (wr_en) begin
            case (addr)
                ADDR_START:  begin stg_nx.sx  = wr_data[11:0]; stg_nx.sy  = wr_data[27:16]; end
                ADDR_END:    begin stg_nx.ex  = wr_data[11:0]; stg_nx.ey  = wr_data[27:16]; end
                ADDR_OUTRES: begin stg_nx.oxr = wr_data[11:0]; stg_nx.oyr = wr_data[27:16]; end
                ADDR_CTRL:   begin stg_nx.mode = wr_data[1:0]; stg_nx.sen = wr_data[2]; end
                default: ;
            endcase
        end
    end

    always_comb begin
        apply   = wr_en && (addr == ADDR_CTRL) && wr_data[31];
        accept  = apply && ((state == ST_IDLE) || (state == ST_PEND) || (state == ST_COMMIT));
        vs_rise = vs_i && !vs_q;
        busy    = (state == ST_CHECK) || (state == ST_DIVX) || (state == ST_DIVY);
        pending = (state == ST_PEND);
        commit  = (state == ST_COMMIT);
    end

    // The width/height ratio limit keeps every quotient below 16.0 in Q4.14.
    always_comb begin
        in_w     = snap.ex - snap.sx;
        in_h     = snap.ey - snap.sy;
        lim_w    = ({5'd0, snap.oxr} + (CFG_W+5)'(1)) << 4;
        lim_h    = ({5'd0, snap.oyr} + (CFG_W+5)'(1)) << 4;
        geom_bad = (snap.ex <= snap.sx) || (snap.ey <= snap.sy)
                || ({1'b0, snap.ex} > H_MAX) || ({1'b0, snap.ey} > V_MAX)
                || ({5'd0, in_w} >= lim_w) || ({5'd0, in_h} >= lim_h);
        div_start = ((state == ST_CHECK) && !geom_bad) || ((state == ST_DIVX) && div_done);
        div_dvd   = (state == ST_CHECK) ? (DVD_W'(in_w) << SCALE_FRAC) : (DVD_W'(in_h) << SCALE_FRAC);
        div_dsr   = (state == ST_CHECK) ? snap.oxr : snap.oyr;
    end

    vp_div_serial u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (div_start),
        .dividend   (div_dvd),
        .divisor_m1 (div_dsr),
        .done       (div_done),
        .quotient   (div_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            stg     <= CFG_RST;
            snap    <= CFG_RST;
            act     <= CFG_RST;
            res_xs  <= SCALE_RST;
            res_ys  <= SCALE_RST;
            act_xs  <= SCALE_RST;
            act_ys  <= SCALE_RST;
            cfg_err <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            vs_q <= vs_i;
            stg  <= stg_nx;
            case (state)
                ST_IDLE, ST_COMMIT, ST_PEND: begin
                    if (accept) begin
                        snap    <= stg_nx;
                        cfg_err <= 1'b0;
                        state   <= ST_CHECK;
                    end else if ((state == ST_PEND) && vs_rise) begin
                        act    <= snap;
                        act_xs <= res_xs;
                        act_ys <= res_ys;
                        state  <= ST_COMMIT;
                    end else if (state == ST_COMMIT) begin
                        state <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (geom_bad) begin
                        cfg_err <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        state <= ST_DIVX;
                    end
                end
                ST_DIVX: if (div_done) begin res_xs <= div_q; state <= ST_DIVY; end
                ST_DIVY: if (div_done) begin res_ys <= div_q; state <= ST_PEND; end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        start_x     = act.sx;
        start_y     = act.sy;
        end_x       = act.ex;
        end_y       = act.ey;
        out_x_res   = act.oxr;
        out_y_res   = act.oyr;
        x_scale     = act_xs;
        y_scale     = act_ys;
        filter_mode = act.mode;
        scaler_en   = act.sen;
        case (addr)
            ADDR_START:  rd_data = pack_xy(stg.sx, stg.sy);
            ADDR_END:    rd_data = pack_xy(stg.ex, stg.ey);
            ADDR_OUTRES: rd_data = pack_xy(stg.oxr, stg.oyr);
            ADDR_CTRL:   rd_data = {29'd0, stg.sen, stg.mode};
            ADDR_STATUS: rd_data = {29'd0, cfg_err, pending, busy};
            default:     rd_data = '0;
        endcase
    end

endmodule
